// File: rtl/sd_multiblock_reader.sv
// SPI-mode SD initialiser and multi-block reader that writes packed pixels to a framebuffer.
// Latency: one SPI byte outstanding at a time; a pixel strobe follows the cycle after its last byte.
// Backpressure: paced entirely by spi_done; the framebuffer write port is assumed always ready.
// Ports: clk/reset/start control; spi_start/spi_done/spi_data_in/spi_data_out to the byte engine;
//        cs to the card; pixel_data/pixel_addr/write_enable to the framebuffer; busy/done/error/err_code status.
module sd_multiblock_reader #(
    parameter int PIXEL_BYTES   = 2,
    parameter int ADDR_W        = 17,
    parameter int START_BLOCK   = 0,
    parameter int NUM_BLOCKS    = 150,
    parameter int BLOCK_ADDR    = 1,
    parameter int INIT_DUMMY    = 10,
    parameter int R1_TIMEOUT    = 16,
    parameter int TOKEN_TIMEOUT = 4096,
    parameter int ACMD_RETRIES  = 1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [7:0]               spi_data_out,
    input  logic                     spi_done,
    output logic                     spi_start,
    output logic [7:0]               spi_data_in,
    output logic                     cs,
    output logic [8*PIXEL_BYTES-1:0] pixel_data,
    output logic [ADDR_W-1:0]        pixel_addr,
    output logic                     write_enable,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [2:0]               err_code
);
    localparam int PW    = 8 * PIXEL_BYTES;
    localparam int CNT_W = 17;
    localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(INIT_DUMMY - 1);
    localparam logic [CNT_W-1:0] R1_LAST    = CNT_W'(R1_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TOKEN_LAST = CNT_W'(TOKEN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ACMD_LAST  = CNT_W'(ACMD_RETRIES - 1);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(511);
    localparam logic [31:0]      BLK_LAST   = 32'(NUM_BLOCKS - 1);
    localparam logic [1:0]       PIX_LAST   = 2'(PIXEL_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_POWERUP, S_SEND, S_WAIT_R1, S_TAIL,
        S_TOKEN, S_DATA, S_CRC, S_NEXT, S_DONE, S_ERROR
    } state_t;

    typedef enum logic [2:0] {
        C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD16, C_CMD17
    } cmd_t;

    state_t             state_q, state_d;
    cmd_t               cmd_q, cmd_d;
    logic               pend_q, pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   retry_q, retry_d;
    logic [31:0]        blk_q, blk_d;
    logic [31:0]        nblk_q, nblk_d;
    logic               tail_ok_q, tail_ok_d;
    logic [PW-1:0]      pix_sr_q, pix_sr_d;
    logic [1:0]         pix_cnt_q, pix_cnt_d;
    logic [PW-1:0]      pixel_q, pixel_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [2:0]         err_q, err_d;

    logic               launch;
    logic               got;
    logic [PW-1:0]      sr_next;
    logic [5:0]         cmd_idx;
    logic [31:0]        cmd_arg;
    logic [7:0]         cmd_crc;
    logic [7:0]         frame_byte;

    // A done pulse only counts while a byte is actually outstanding, so a
    // stray completion after reset cannot advance the sequence.
    assign got     = pend_q && spi_done;
    assign sr_next = (pix_sr_q << 8) | PW'(spi_data_out);

    // Command frame byte selected by the frame byte index in cnt_q.
    always_comb begin
        cmd_idx    = 6'd0;
        cmd_arg    = 32'd0;
        cmd_crc    = 8'hFF;
        frame_byte = 8'hFF;
        case (cmd_q)
            C_CMD0:   begin cmd_idx = 6'd0;  cmd_crc = 8'h95; end
            C_CMD8:   begin cmd_idx = 6'd8;  cmd_arg = 32'h0000_01AA; cmd_crc = 8'h87; end
            C_CMD55:  cmd_idx = 6'd55;
            C_ACMD41: begin cmd_idx = 6'd41; cmd_arg = 32'h4000_0000; end
            C_CMD16:  begin cmd_idx = 6'd16; cmd_arg = 32'd512; end
            C_CMD17:  begin
                cmd_idx = 6'd17;
                cmd_arg = (BLOCK_ADDR != 0) ? blk_q : {blk_q[22:0], 9'd0};
            end
            default:  cmd_idx = 6'd0;
        endcase
        case (cnt_q[2:0])
            3'd0:    frame_byte = {2'b01, cmd_idx};
            3'd1:    frame_byte = cmd_arg[31:24];
            3'd2:    frame_byte = cmd_arg[23:16];
            3'd3:    frame_byte = cmd_arg[15:8];
            3'd4:    frame_byte = cmd_arg[7:0];
            default: frame_byte = cmd_crc;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        blk_d     = blk_q;
        nblk_d    = nblk_q;
        tail_ok_d = tail_ok_q;
        pix_sr_d  = pix_sr_q;
        pix_cnt_d = pix_cnt_q;
        pixel_d   = pixel_q;
        we_d      = 1'b0;
        addr_d    = we_q ? addr_q + 1'b1 : addr_q;
        err_d     = err_q;

        launch = (state_q == S_POWERUP) || (state_q == S_SEND) || (state_q == S_WAIT_R1) ||
                 (state_q == S_TAIL) || (state_q == S_TOKEN) || (state_q == S_DATA) ||
                 (state_q == S_CRC);
        spi_start   = launch && !pend_q;
        spi_data_in = (state_q == S_SEND) ? frame_byte : 8'hFF;
        cs          = (state_q == S_IDLE) || (state_q == S_POWERUP) ||
                      (state_q == S_DONE) || (state_q == S_ERROR);
        busy        = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
        done        = (state_q == S_DONE);
        error       = (state_q == S_ERROR);

        pend_d = pend_q;
        if (spi_start)     pend_d = 1'b1;
        else if (spi_done) pend_d = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d   = S_POWERUP;
                    cnt_d     = '0;
                    retry_d   = '0;
                    blk_d     = 32'(START_BLOCK);
                    nblk_d    = '0;
                    pix_cnt_d = '0;
                    addr_d    = '0;
                    err_d     = 3'd0;
                end
            end
            S_POWERUP: if (got) begin
                if (cnt_q == DUMMY_LAST) begin
                    state_d = S_SEND;
                    cmd_d   = C_CMD0;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 1'b1;
            end
            S_SEND: if (got) begin
                cnt_d = (cnt_q == CNT_W'(5)) ? '0 : cnt_q + 1'b1;
                if (cnt_q == CNT_W'(5)) state_d = S_WAIT_R1;
            end
            S_WAIT_R1: if (got) begin
                if (!spi_data_out[7]) begin
                    cnt_d   = '0;
                    state_d = S_SEND;
                    case (cmd_q)
                        C_CMD0: begin
                            cmd_d = C_CMD8;
                            if (spi_data_out != 8'h01) begin state_d = S_ERROR; err_d = 3'd1; end
                        end
                        C_CMD8: begin
                            state_d = S_TAIL;
                            if (spi_data_out != 8'h01) begin state_d = S_ERROR; err_d = 3'd2; end
                        end
                        C_CMD55: cmd_d = C_ACMD41;
                        C_ACMD41: begin
                            if (spi_data_out == 8'h00) cmd_d = C_CMD16;
                            else if (retry_q == ACMD_LAST) begin state_d = S_ERROR; err_d = 3'd3; end
                            else begin retry_d = retry_q + 1'b1; cmd_d = C_CMD55; end
                        end
                        C_CMD16: begin
                            cmd_d = C_CMD17;
                            if (spi_data_out != 8'h00) begin state_d = S_ERROR; err_d = 3'd4; end
                        end
                        default: begin
                            state_d = S_TOKEN;
                            if (spi_data_out != 8'h00) begin state_d = S_ERROR; err_d = 3'd4; end
                        end
                    endcase
                end else if (cnt_q == R1_LAST) begin
                    state_d = S_ERROR;
                    err_d   = 3'd5;
                end else cnt_d = cnt_q + 1'b1;
            end
            // CMD8 R7 tail: only the last two bytes (voltage echo and check pattern) matter.
            S_TAIL: if (got) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(2)) tail_ok_d = (spi_data_out == 8'h01);
                if (cnt_q == CNT_W'(3)) begin
                    cnt_d   = '0;
                    retry_d = '0;
                    cmd_d   = C_CMD55;
                    state_d = S_SEND;
                    if (!(tail_ok_q && spi_data_out == 8'hAA)) begin state_d = S_ERROR; err_d = 3'd2; end
                end
            end
            S_TOKEN: if (got) begin
                if (spi_data_out == 8'hFE) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else if (spi_data_out[7:4] == 4'h0 || cnt_q == TOKEN_LAST) begin
                    state_d = S_ERROR;
                    err_d   = 3'd6;
                end else cnt_d = cnt_q + 1'b1;
            end
            S_DATA: if (got) begin
                pix_sr_d = sr_next;
                if (pix_cnt_q == PIX_LAST) begin
                    pix_cnt_d = '0;
                    pixel_d   = sr_next;
                    we_d      = 1'b1;
                end else pix_cnt_d = pix_cnt_q + 1'b1;
                cnt_d = (cnt_q == DATA_LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q == DATA_LAST) state_d = S_CRC;
            end
            S_CRC: if (got) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(1)) begin cnt_d = '0; state_d = S_NEXT; end
            end
            S_NEXT: begin
                blk_d = blk_q + 1'b1;
                if (nblk_q == BLK_LAST) state_d = S_DONE;
                else begin
                    nblk_d  = nblk_q + 1'b1;
                    cmd_d   = C_CMD17;
                    state_d = S_SEND;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cmd_q     <= C_CMD0;
            pend_q    <= 1'b0;
            cnt_q     <= '0;
            retry_q   <= '0;
            blk_q     <= '0;
            nblk_q    <= '0;
            tail_ok_q <= 1'b0;
            pix_sr_q  <= '0;
            pix_cnt_q <= '0;
            pixel_q   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            err_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            blk_q     <= blk_d;
            nblk_q    <= nblk_d;
            tail_ok_q <= tail_ok_d;
            pix_sr_q  <= pix_sr_d;
            pix_cnt_q <= pix_cnt_d;
            pixel_q   <= pixel_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
        end
    end

    assign pixel_data   = pixel_q;
    assign pixel_addr   = addr_q;
    assign write_enable = we_q;
    assign err_code     = err_q;
endmodule

// File: tb/tb_sd_multiblock_reader.sv
// Bench for sd_multiblock_reader with a behavioural SPI byte engine and SD card.
// Latency: each byte exchange completes two cycles after spi_start.
// Backpressure: none; the card model answers every launched byte.
module tb_sd_multiblock_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  spi_data_out = 8'hFF;
    logic        spi_done = 1'b0;
    logic        spi_start;
    logic [7:0]  spi_data_in;
    logic        cs;
    logic [15:0] pixel_data;
    logic [16:0] pixel_addr;
    logic        write_enable, busy, done, error;
    logic [2:0]  err_code;

    always #5 clk = ~clk;

    sd_multiblock_reader #(
        .PIXEL_BYTES(2), .ADDR_W(17), .START_BLOCK(3), .NUM_BLOCKS(2), .BLOCK_ADDR(0),
        .INIT_DUMMY(10), .R1_TIMEOUT(16), .TOKEN_TIMEOUT(64), .ACMD_RETRIES(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .spi_data_out(spi_data_out),
        .spi_done(spi_done), .spi_start(spi_start), .spi_data_in(spi_data_in), .cs(cs),
        .pixel_data(pixel_data), .pixel_addr(pixel_addr), .write_enable(write_enable),
        .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    int checks = 0;
    int fails  = 0;

    // Card behaviour knobs
    logic [7:0] k_cmd0_r1 = 8'h01;
    logic [7:0] k_echo    = 8'hAA;
    bit         k_silent  = 1'b0;
    int         k_acmd_busy = 2;
    int         k_tok = 0;        // 0 data, 1 error token, 2 no token
    int         acmd_n = 0;

    logic [7:0]  resp[$];
    logic [7:0]  tx_byte[$];
    logic        tx_cs[$];
    logic [47:0] frames[$];
    logic [15:0] wr_dat[$];
    logic [16:0] wr_adr[$];
    logic [47:0] fr = '0;
    int          fcnt = 0;
    int          hold_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic on_cmd(input logic [47:0] f);
        case (f[45:40])
            6'd0:  if (!k_silent) begin resp.push_back(8'hFF); resp.push_back(k_cmd0_r1); end
            6'd8:  begin
                resp.push_back(8'hFF); resp.push_back(8'h01); resp.push_back(8'h00);
                resp.push_back(8'h00); resp.push_back(8'h01); resp.push_back(k_echo);
            end
            6'd55: resp.push_back(8'h01);
            6'd41: begin
                resp.push_back((acmd_n < k_acmd_busy) ? 8'h01 : 8'h00);
                acmd_n++;
            end
            6'd16: resp.push_back(8'h00);
            6'd17: begin
                resp.push_back(8'h00);
                if (k_tok == 0) begin
                    resp.push_back(8'hFF); resp.push_back(8'hFF); resp.push_back(8'hFE);
                    for (int i = 0; i < 512; i++) resp.push_back(8'(i));
                    resp.push_back(8'hAB); resp.push_back(8'hCD);
                end else if (k_tok == 1) resp.push_back(8'h05);
            end
            default: ;
        endcase
    endtask

    task automatic card_rx(input logic [7:0] mosi, input logic csv);
        if (fcnt > 0) begin
            fr = {fr[39:0], mosi};
            fcnt++;
            if (fcnt == 6) begin
                frames.push_back(fr);
                on_cmd(fr);
                fcnt = 0;
            end
        end else if (csv == 1'b0 && mosi[7:6] == 2'b01) begin
            fr = {40'd0, mosi};
            fcnt = 1;
        end
    endtask

    // SPI byte engine + card
    initial begin
        logic [7:0] mosi, miso;
        logic       csv;
        forever begin
            @(negedge clk);
            while (spi_start === 1'b1) begin
                mosi = spi_data_in;
                csv  = cs;
                tx_byte.push_back(mosi);
                tx_cs.push_back(csv);
                miso = (resp.size() > 0) ? resp.pop_front() : 8'hFF;
                @(negedge clk);
                if (spi_data_in !== mosi) hold_err++;
                spi_data_out = miso;
                spi_done = 1'b1;
                @(negedge clk);
                spi_done = 1'b0;
                spi_data_out = 8'hFF;
                card_rx(mosi, csv);
            end
        end
    end

    // Framebuffer write monitor
    initial forever begin
        @(negedge clk);
        if (write_enable === 1'b1) begin
            wr_dat.push_back(pixel_data);
            wr_adr.push_back(pixel_addr);
        end
    end

    task automatic clear_model();
        resp.delete(); tx_byte.delete(); tx_cs.delete(); frames.delete();
        wr_dat.delete(); wr_adr.delete();
        fcnt = 0; acmd_n = 0; hold_err = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
        checks++;
        if (n >= 20000) begin fails++; $display("FAIL %s: still busy after %0d cycles, required idle", name, n); end
    endtask

    task automatic check_pixels(input string name);
        int bad = 0;
        for (int k = 0; k < wr_dat.size(); k++) begin
            if (wr_dat[k] !== {8'(2*k), 8'(2*k+1)} || wr_adr[k] !== 17'(k)) bad++;
        end
        check(name, 64'(bad), 64'd0);
    endtask

    typedef struct {
        logic [7:0] cmd0_r1;
        logic [7:0] echo;
        bit         silent;
        int         acmd_busy;
        int         tok;
        logic       exp_done;
        logic       exp_err;
        logic [2:0] exp_code;
        int         exp_wr;
        int         exp_tx;
    } scen_t;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    initial begin
        scen_t tbl[7];
        logic [47:0] ff;
        logic [47:0] f17[$];
        int nd, nonff, csz;

        tbl[0] = '{8'h01, 8'hAA, 1'b0, 2,   0, 1'b1, 1'b0, 3'd0, 512, 1127};
        tbl[1] = '{8'h01, 8'h55, 1'b0, 2,   0, 1'b0, 1'b1, 3'd2, 0,   30};
        tbl[2] = '{8'h01, 8'hAA, 1'b1, 2,   0, 1'b0, 1'b1, 3'd5, 0,   32};
        tbl[3] = '{8'h01, 8'hAA, 1'b0, 2,   1, 1'b0, 1'b1, 3'd6, 0,   87};
        tbl[4] = '{8'h01, 8'hAA, 1'b0, 2,   2, 1'b0, 1'b1, 3'd6, 0,   150};
        tbl[5] = '{8'h01, 8'hAA, 1'b0, 100, 0, 1'b0, 1'b1, 3'd3, 0,   86};
        tbl[6] = '{8'h05, 8'hAA, 1'b0, 2,   0, 1'b0, 1'b1, 3'd1, 0,   18};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ctrl", {cs, spi_start, spi_data_in, write_enable, busy, done, error, err_code},
              {1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
        check("reset_pixel", {pixel_data, pixel_addr}, 33'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Full normal run with detailed checks
        clear_model();
        pulse_start();
        check("busy_after_start", busy, 1'b1);
        wait_idle("normal_run");
        check("normal_status", {done, error, busy, cs}, 4'b1001);
        nd = 0;
        while (nd < tx_cs.size() && tx_cs[nd] == 1'b1) nd++;
        check("dummy_count", 64'(nd), 64'd10);
        nonff = 0;
        for (int i = 0; i < nd; i++) if (tx_byte[i] != 8'hFF) nonff++;
        check("dummy_bytes_ff", 64'(nonff), 64'd0);
        ff = '0;
        csz = 0;
        if (tx_byte.size() >= 16)
            for (int i = 10; i < 16; i++) begin ff = {ff[39:0], tx_byte[i]}; csz += int'(tx_cs[i]); end
        check("first_frame", ff, 48'h40_00_00_00_00_95);
        check("first_frame_cs_low", 64'(csz), 64'd0);
        for (int i = 0; i < frames.size(); i++) if (frames[i][45:40] == 6'd17) f17.push_back(frames[i]);
        check("cmd17_count", 64'(f17.size()), 64'd2);
        if (f17.size() == 2) begin
            check("cmd17_first", f17[0], 48'h51_00_00_06_00_FF);
            check("cmd17_second", f17[1], 48'h51_00_00_08_00_FF);
        end
        check("acmd41_iterations", 64'(acmd_n), 64'd3);
        check("write_count", 64'(wr_dat.size()), 64'd512);
        if (wr_dat.size() == 512) begin
            check("pixel0", {wr_dat[0], wr_adr[0]}, {16'h0001, 17'd0});
            check("pixel511", {wr_dat[511], wr_adr[511]}, {16'hFEFF, 17'd511});
        end
        check_pixels("pixel_stream");
        check("data_hold", 64'(hold_err), 64'd0);

        // Reset mid-DATA, then fresh run with a start pulse while busy
        clear_model();
        pulse_start();
        begin
            int n = 0;
            while (wr_dat.size() < 100 && n < 20000) begin @(negedge clk); n++; end
            check("reached_byte_200", 64'(wr_dat.size() >= 100), 64'd1);
        end
        reset = 1'b1;
        @(negedge clk);
        check("midreset_outputs", {cs, write_enable, pixel_addr, busy}, {1'b1, 1'b0, 17'd0, 1'b0});
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("late_done_ignored", {busy, cs, write_enable}, 3'b010);
        clear_model();
        pulse_start();
        repeat (50) @(negedge clk);
        pulse_start();
        wait_idle("rerun");
        check("rerun_status", {done, error, cs}, 3'b101);
        check("rerun_writes", 64'(wr_dat.size()), 64'd512);
        check_pixels("rerun_pixels");
        csz = 0;
        foreach (tx_cs[i]) csz += int'(tx_cs[i]);
        check("rerun_cs_high_bytes", 64'(csz), 64'd10);

        // Scenario table
        for (int s = 0; s < 7; s++) begin
            k_cmd0_r1 = tbl[s].cmd0_r1;
            k_echo = tbl[s].echo;
            k_silent = tbl[s].silent;
            k_acmd_busy = tbl[s].acmd_busy;
            k_tok = tbl[s].tok;
            clear_model();
            pulse_start();
            wait_idle($sformatf("scen%0d_idle", s));
            check($sformatf("scen%0d_status", s), {done, error, err_code, busy, cs},
                  {tbl[s].exp_done, tbl[s].exp_err, tbl[s].exp_code, 1'b0, 1'b1});
            check($sformatf("scen%0d_writes", s), 64'(wr_dat.size()), 64'(tbl[s].exp_wr));
            check($sformatf("scen%0d_bytes", s), 64'(tx_byte.size()), 64'(tbl[s].exp_tx));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/sd_multiblock_reader.md
Name: sd_multiblock_reader

Overview:
- SPI-mode SD card initialiser and multi-block reader that feeds the framebuffer.
- Drives the shared byte-level SPI engine through spi_start/spi_done/spi_data_in/spi_data_out.
- Sends full 6-byte command frames and runs the complete init sequence: CMD0, CMD8, CMD55/ACMD41 loop, CMD16.
- Then reads NUM_BLOCKS consecutive 512-byte blocks from START_BLOCK, packs bytes into PIXEL_BYTES-wide pixels and writes them to sequential framebuffer addresses. Timeouts and error reporting included.

Parameters:
PIXEL_BYTES, 2, bytes per pixel; legal values 1, 2, 4.
ADDR_W, 17, framebuffer address width.
START_BLOCK, 0, first block number read.
NUM_BLOCKS, 150, blocks read per start.
BLOCK_ADDR, 1, 1 = CMD17 argument is the block number (SDHC); 0 = argument is block*512 (SDSC).
INIT_DUMMY, 10, 0xFF bytes sent with cs high before CMD0.
R1_TIMEOUT, 16, max poll bytes while waiting for R1.
TOKEN_TIMEOUT, 4096, max poll bytes while waiting for the data token.
ACMD_RETRIES, 1000, max CMD55/ACMD41 iterations.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins init and read; ignored while busy=1
spi_data_out  in  8  byte received; valid when spi_done=1
spi_done  in  1  one-cycle pulse; byte exchange complete
spi_start  out  1  one-cycle pulse; launch byte exchange
spi_data_in  out  8  byte to transmit; held stable from spi_start until spi_done
cs  out  1  card chip select, active low
pixel_data  out  8*PIXEL_BYTES  packed pixel
pixel_addr  out  ADDR_W  framebuffer address of pixel_data
write_enable  out  1  one-cycle framebuffer write strobe
busy  out  1  high from start accepted until DONE/ERROR
done  out  1  level; all blocks read
error  out  1  level; sequence aborted
err_code  out  3  cause of the abort; valid while error=1

Behaviour:
- Reset values: cs=1, spi_start=0, spi_data_in=0xFF, pixel_data=0, pixel_addr=0, write_enable=0, busy=0, done=0, error=0, err_code=0, state=IDLE. Reset mid-transfer aborts immediately; any late spi_done is ignored.
- SPI handshake: at most one byte outstanding. spi_start is asserted only in a state waiting to launch. The next byte launches no earlier than the cycle after spi_done.
- Poll bytes transmit 0xFF.
- Command frame: bytes {0x40|idx, arg[31:24], arg[23:16], arg[15:8], arg[7:0], crc}, MSB first.
  - crc = 0x95 for CMD0, 0x87 for CMD8, 0xFF otherwise.
  - CMD8 arg = 0x000001AA; ACMD41 arg = 0x40000000; CMD16 arg = 512.
- R1 wait: poll until a byte with bit7=0 arrives. If R1_TIMEOUT bytes pass without one, go to ERROR with code 5.
- States:
  - IDLE: cs=1. On start: busy=1, done=0, error=0, pixel_addr=0, go to POWERUP.
  - POWERUP: send INIT_DUMMY bytes with cs=1, then cs=0 and go to CMD0.
  - CMD0: expected R1=0x01; otherwise ERROR code 1.
  - CMD8: R1=0x01, then 4 tail bytes. If the last two tail bytes are not 0x01, 0xAA, ERROR code 2.
  - ACMD: send CMD55 and discard its R1, then send ACMD41.
    - R1=0x00: go to CMD16.
    - Otherwise: increment the retry counter and repeat the loop.
    - After ACMD_RETRIES iterations without R1=0x00: ERROR code 3.
  - CMD16: R1 must be 0x00; otherwise ERROR code 4.
  - READ_CMD: CMD17 with arg = blk if BLOCK_ADDR=1, blk<<9 if BLOCK_ADDR=0. blk starts at START_BLOCK. R1 must be 0x00; otherwise ERROR code 4.
  - TOKEN: poll for 0xFE.
    - A byte with upper nibble 0 (data error token): ERROR code 6.
    - TOKEN_TIMEOUT exceeded: ERROR code 6.
  - DATA: 512 bytes, then CRC_SKIP (2 bytes discarded).
  - NEXT: blk+1. If NUM_BLOCKS blocks are done, go to DONE; else go to READ_CMD.
  - DONE: cs=1, busy=0, done=1. Held until the next start or reset.
  - ERROR: cs=1, busy=0, error=1, err_code latched. Held until the next start or reset.
- Pixel packing:
  - Big-endian: the first byte received lands in pixel_data[8*PIXEL_BYTES-1 -: 8].
  - On the spi_done of the PIXEL_BYTES-th byte, pixel_data updates and write_enable pulses the next cycle with the current pixel_addr. pixel_addr increments the cycle after the strobe.
  - First pixel is written to address 0.
  - The packing counter persists across block boundaries; 512 % PIXEL_BYTES = 0, so no pixel straddles a CRC.
- pixel_addr wraps modulo 2^ADDR_W; no error is raised on wrap.
- start while busy=1 is ignored. start on the same cycle as reset: reset wins.

Test Plan:
- Card model responding 0x01, 0x01+{00,00,01,AA}, ACMD41 0x01 twice then 0x00, CMD16 0x00; 2 blocks of bytes 0..255 repeated, PIXEL_BYTES=2, NUM_BLOCKS=2 -> 10 dummies with cs=1; first frame 40 00 00 00 00 95; 512 writes; pixel[0]=0x0001 at addr 0; pixel[511]=0xFEFF at addr 511; done=1; cs=1.
- CMD8 echo 0x55 instead of 0xAA -> error=1, err_code=2, busy=0, cs=1, no writes.
- Card never answers (MISO 0xFF), R1_TIMEOUT=16 -> exactly 16 poll bytes after CMD0 frame, then err_code=5.
- Token 0x05 after CMD17 -> err_code=6, zero writes. Separately, 0xFF for TOKEN_TIMEOUT bytes -> err_code=6.
- BLOCK_ADDR=0, START_BLOCK=3 -> second CMD17 frame 51 00 00 08 00 FF. BLOCK_ADDR=1 -> 51 00 00 00 04 FF.
- Reset asserted mid-DATA at byte 200 -> next cycle cs=1, write_enable=0, pixel_addr=0. A fresh start re-runs POWERUP and completes normally. A start pulse during busy has no effect.
